// File: rtl/seq_magnitude_comparator.sv
// rtl/seq_magnitude_comparator.sv - multi-cycle sliced signed/unsigned magnitude comparator
//
// Purpose:
//   Compares two WIDTH-bit operands SLICE bits per cycle, most significant
//   slice first. The mode is chosen per operation: two's-complement or
//   unsigned. The result is registered and is returned through a
//   valid/ready handshake.
//
// Build option:
//   SEQ_CMP_EARLY_EXIT_EN
//     defined   - the compare finishes on the first slice that differs, so
//                 latency depends on the data (1..NSLICE cycles).
//     undefined - constant-time operation: every slice is stepped, and
//                 latency is always NSLICE cycles.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous reset, active-high
//   in_valid     in   a, b and signed_mode carry an operation
//   in_ready     out  block is idle and can accept an operation
//   a, b         in   WIDTH-bit operands
//   signed_mode  in   1 = two's-complement compare, 0 = unsigned
//   out_valid    out  less/equal/greater hold a result
//   out_ready    in   consumer takes the result
//   less         out  A <  B (one-hot with equal/greater while out_valid)
//   equal        out  A == B
//   greater      out  A >  B
//   busy         out  an operation is in flight or its result is pending

module seq_magnitude_comparator #(
    parameter int WIDTH = 64,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             less,
    output logic             equal,
    output logic             greater,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t            r_state;

    // Operand copies are shifted left one slice per COMPARE cycle, so the
    // slice under test is always the top SLICE bits. This keeps the datapath
    // to a fixed slice compare and avoids a wide variable-index mux.
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_signed;
    logic [IW-1:0]     r_idx;

    logic              r_out_valid;
    logic              r_less;
    logic              r_equal;
    logic              r_greater;

`ifndef SEQ_CMP_EARLY_EXIT_EN
    // Constant-time mode: the first differing slice decides the result.
    // Later slices are still stepped but cannot change the decision.
    logic              r_decided;
    logic              r_dec_lt;
    logic              r_dec_gt;
`endif

    logic [SLICE-1:0]  w_top_a;
    logic [SLICE-1:0]  w_top_b;
    logic              w_flip_msb;
    logic [SLICE-1:0]  w_slice_a;
    logic [SLICE-1:0]  w_slice_b;
    logic              w_lt;
    logic              w_gt;
    logic              w_diff;
    logic              w_last;
    logic [WIDTH-1:0]  w_a_next;
    logic [WIDTH-1:0]  w_b_next;

    assign w_top_a = r_a[WIDTH-1 -: SLICE];
    assign w_top_b = r_b[WIDTH-1 -: SLICE];

    // A signed compare reduces to an unsigned compare once the sign bits are
    // inverted. Only the top slice carries the sign bit.
    assign w_flip_msb = r_signed && (r_idx == LAST_IDX);

    assign w_slice_a = {w_top_a[SLICE-1] ^ w_flip_msb, w_top_a[SLICE-2:0]};
    assign w_slice_b = {w_top_b[SLICE-1] ^ w_flip_msb, w_top_b[SLICE-2:0]};

    assign w_lt   = (w_slice_a < w_slice_b);
    assign w_gt   = (w_slice_a > w_slice_b);
    assign w_diff = w_lt | w_gt;
    assign w_last = (r_idx == '0);

    assign w_a_next = {r_a[WIDTH-SLICE-1:0], {SLICE{1'b0}}};
    assign w_b_next = {r_b[WIDTH-SLICE-1:0], {SLICE{1'b0}}};

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign less      = r_less;
    assign equal     = r_equal;
    assign greater   = r_greater;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_signed    <= 1'b0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_less      <= 1'b0;
            r_equal     <= 1'b0;
            r_greater   <= 1'b0;
`ifndef SEQ_CMP_EARLY_EXIT_EN
            r_decided   <= 1'b0;
            r_dec_lt    <= 1'b0;
            r_dec_gt    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    // in_ready is 1 throughout IDLE, so in_valid alone
                    // completes the input handshake.
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_signed <= signed_mode;
                        r_idx    <= LAST_IDX;
`ifndef SEQ_CMP_EARLY_EXIT_EN
                        r_decided <= 1'b0;
                        r_dec_lt  <= 1'b0;
                        r_dec_gt  <= 1'b0;
`endif
                        r_state  <= S_COMPARE;
                    end
                end

                S_COMPARE: begin
                    r_a <= w_a_next;
                    r_b <= w_b_next;
`ifdef SEQ_CMP_EARLY_EXIT_EN
                    if (w_diff) begin
                        r_less      <= w_lt;
                        r_greater   <= w_gt;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_last) begin
                        r_equal     <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
`else
                    if (!r_decided && w_diff) begin
                        r_decided <= 1'b1;
                        r_dec_lt  <= w_lt;
                        r_dec_gt  <= w_gt;
                    end
                    if (w_last) begin
                        // The final slice may be the first difference, so
                        // its live compare is used when nothing has been
                        // latched yet.
                        r_less      <= r_decided ? r_dec_lt : w_lt;
                        r_greater   <= r_decided ? r_dec_gt : w_gt;
                        r_equal     <= !r_decided && !w_diff;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
`endif
                end

                S_DONE: begin
                    // Results stay frozen, and new requests are ignored,
                    // until the consumer takes the result.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_less      <= 1'b0;
                        r_equal     <= 1'b0;
                        r_greater   <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_less      <= 1'b0;
                    r_equal     <= 1'b0;
                    r_greater   <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb/tb_seq_magnitude_comparator.sv - directed self-checking bench for seq_magnitude_comparator

module tb_seq_magnitude_comparator;

`ifdef SEQ_CMP_EARLY_EXIT_EN
    localparam int LAT_TOP = 1;
`else
    localparam int LAT_TOP = 8;
`endif
    localparam int LAT_FULL = 8;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        signed_mode;
    logic        out_valid;
    logic        out_ready;
    logic        less;
    logic        equal;
    logic        greater;
    logic        busy;

    int n_checks;
    int n_fail;

    seq_magnitude_comparator #(.WIDTH(64), .SLICE(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .less        (less),
        .equal       (equal),
        .greater     (greater),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operation and count the edges from acceptance until
    // out_valid is seen. The count stops at 40 edges.
    task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_v,
                          input logic tm, output int lat);
        a = ta;
        b = tb_v;
        signed_mode = tm;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        signed_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if ({out_valid, less, equal, greater} !== 4'b0000)
            begin n_fail++; $display("FAIL reset_outputs: got %b expected 0000", {out_valid, less, equal, greater}); end
    endtask

    task automatic test_unsigned_top();
        int lat;
        run_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, lat);
        n_checks++;
        if (lat !== LAT_TOP) begin n_fail++; $display("FAIL s1_latency: got %0d expected %0d", lat, LAT_TOP); end
        n_checks++;
        if ({less, equal, greater} !== 3'b001)
            begin n_fail++; $display("FAIL s1_result: got %b expected 001", {less, equal, greater}); end
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0)
            begin n_fail++; $display("FAIL s1_busy_done: got busy=%b in_ready=%b expected 1 0", busy, in_ready); end
        release_result();
    endtask

    task automatic test_signed_top();
        int lat;
        run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, lat);
        n_checks++;
        if (lat !== LAT_TOP) begin n_fail++; $display("FAIL s2_latency: got %0d expected %0d", lat, LAT_TOP); end
        n_checks++;
        if ({less, equal, greater} !== 3'b100)
            begin n_fail++; $display("FAIL s2_result: got %b expected 100", {less, equal, greater}); end
        release_result();
    endtask

    task automatic test_equal();
        int lat;
        for (int m = 0; m < 2; m++) begin
            run_op(64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, m[0], lat);
            n_checks++;
            if (lat !== LAT_FULL) begin n_fail++; $display("FAIL s3_latency mode=%0d: got %0d expected %0d", m, lat, LAT_FULL); end
            n_checks++;
            if ({less, equal, greater} !== 3'b010)
                begin n_fail++; $display("FAIL s3_result mode=%0d: got %b expected 010", m, {less, equal, greater}); end
            release_result();
        end
    endtask

    task automatic test_low_slice_and_minus_one();
        int lat;
        run_op(64'h0000_0000_0000_0105, 64'h0000_0000_0000_0104, 1'b0, lat);
        n_checks++;
        if (lat !== LAT_FULL) begin n_fail++; $display("FAIL s4a_latency: got %0d expected %0d", lat, LAT_FULL); end
        n_checks++;
        if ({less, equal, greater} !== 3'b001)
            begin n_fail++; $display("FAIL s4a_result: got %b expected 001", {less, equal, greater}); end
        release_result();

        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, lat);
        n_checks++;
        if (lat !== LAT_TOP) begin n_fail++; $display("FAIL s4b_latency: got %0d expected %0d", lat, LAT_TOP); end
        n_checks++;
        if ({less, equal, greater} !== 3'b100)
            begin n_fail++; $display("FAIL s4b_result: got %b expected 100", {less, equal, greater}); end
        release_result();

        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, lat);
        n_checks++;
        if ({less, equal, greater} !== 3'b001)
            begin n_fail++; $display("FAIL s4c_unsigned_ff: got %b expected 001", {less, equal, greater}); end
        release_result();
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(64'h3, 64'h9, 1'b0, lat);
        n_checks++;
        if ({out_valid, less, equal, greater} !== 4'b1100)
            begin n_fail++; $display("FAIL s5_first: got %b expected 1100", {out_valid, less, equal, greater}); end
        for (int c = 0; c < 5; c++) begin
            in_valid = (c == 1);
            a = 64'h9;
            b = 64'h3;
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, less, equal, greater, in_ready} !== 5'b11000)
                begin n_fail++; $display("FAIL s5_hold cyc=%0d: got %b expected 11000", c, {out_valid, less, equal, greater, in_ready}); end
        end
        in_valid = 1'b0;
        release_result();
        n_checks++;
        if ({out_valid, less, equal, greater} !== 4'b0000)
            begin n_fail++; $display("FAIL s5_clear: got %b expected 0000", {out_valid, less, equal, greater}); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL s5_ready: got %b expected 1", in_ready); end
        run_op(64'h9, 64'h3, 1'b0, lat);
        n_checks++;
        if (lat !== LAT_FULL) begin n_fail++; $display("FAIL s5_next_latency: got %0d expected %0d", lat, LAT_FULL); end
        n_checks++;
        if ({less, equal, greater} !== 3'b001)
            begin n_fail++; $display("FAIL s5_next_result: got %b expected 001", {less, equal, greater}); end
        release_result();
    endtask

    task automatic test_reset_mid();
        int lat;
        int stale;
        a = 64'h1234_5678_9ABC_DEF0;
        b = 64'h1234_5678_9ABC_DEF0;
        signed_mode = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL s6_busy: got %b expected 1", busy); end
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({out_valid, in_ready, busy} !== 3'b010)
            begin n_fail++; $display("FAIL s6_after_reset: got %b expected 010", {out_valid, in_ready, busy}); end
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || less !== 1'b0 || equal !== 1'b0 || greater !== 1'b0) stale++;
        end
        n_checks++;
        if (stale !== 0) begin n_fail++; $display("FAIL s6_stale: got %0d cycles with output expected 0", stale); end
        run_op(64'h5, 64'h7, 1'b0, lat);
        n_checks++;
        if (lat !== LAT_FULL) begin n_fail++; $display("FAIL s6_next_latency: got %0d expected %0d", lat, LAT_FULL); end
        n_checks++;
        if ({less, equal, greater} !== 3'b100)
            begin n_fail++; $display("FAIL s6_next_result: got %b expected 100", {less, equal, greater}); end
        release_result();
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_unsigned_top();
        test_signed_top();
        test_equal();
        test_low_slice_and_minus_one();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
Parametrised, multi-cycle successor to the 32-bit combinational signed comparator. It compares two WIDTH-bit operands in SLICE-bit chunks, MSB-first, with a per-operation signed/unsigned mode and early termination on the first differing slice. It sits beside the ALU and serves wide compares (64-bit, compare-and-branch on extended datapaths) through valid/ready handshakes on both sides, so the result path is registered and timing-friendly.

Parameters:
WIDTH, 64, operand width in bits; must be a multiple of SLICE and at least 2*SLICE.
SLICE, 8, bits compared per cycle.
NSLICE, WIDTH/SLICE, derived number of slices; not overridden.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  operands and mode are valid.
in_ready  output  1  block can accept an operation.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned.
out_valid  output  1  result is valid.
out_ready  input  1  consumer accepts the result.
less  output  1  A < B.
equal  output  1  A == B.
greater  output  1  A > B.
busy  output  1  state is not IDLE.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high. While rst is high at an edge: state goes to IDLE, and out_valid, less, equal and greater go to 0. in_ready is 1 and busy is 0 from the next cycle. Reset mid-operation discards the operation and produces no output.
- States are IDLE, COMPARE and DONE. in_ready = (state==IDLE). There is no overlap between operations.
- IDLE: at an edge with in_valid & in_ready, register a, b and signed_mode, set idx = NSLICE-1, and go to COMPARE.
- COMPARE: slice idx of A is compared against slice idx of B as unsigned values. When idx == NSLICE-1 and signed_mode == 1, the MSB of both slices is inverted before the compare.
- On each COMPARE edge:
  - If the slices differ: register less or greater and go to DONE.
  - Else if idx == 0: register equal = 1 and go to DONE.
  - Else: idx decrements.
- Latency from the accept edge to out_valid = 1 ranges from 1 cycle (top slice differs) to NSLICE cycles (difference only in slice 0, or operands equal).
- DONE: out_valid = 1. less, equal and greater are exactly one-hot and held stable until the output handshake. At an edge with out_valid & out_ready: out_valid and all three results clear to 0, and state goes to IDLE. in_ready is 1 in the following cycle.
- While out_valid is 1 and out_ready is 0, all outputs are held and in_valid is ignored.
- less, equal and greater are 0 whenever out_valid is 0.

Optional Feature:
SEQ_CMP_EARLY_EXIT_EN
- Defined: early termination as described above; latency depends on the data.
- Undefined: constant-time operation. The first differing slice's result is latched in a decided flag. Later slices are still stepped but do not change the latched result. DONE is entered only after idx == 0, so latency is always NSLICE cycles regardless of the data.

Test Plan:
Default parameters are used (WIDTH=64, SLICE=8).
1. a=0x8000_0000_0000_0000, b=0x1, signed_mode=0 -> greater=1, less=0, equal=0. out_valid is 1 cycle after accept with early exit, 8 cycles without.
2. Same operands, signed_mode=1 -> less=1 with the same latency as scenario 1.
3. a=b=0xDEAD_BEEF_0123_4567, either mode -> equal=1, out_valid 8 cycles after accept.
4. a=0x0000_0000_0000_0105, b=0x0000_0000_0000_0104, unsigned -> greater=1 at 8 cycles. Then a=0xFFFF_FFFF_FFFF_FFFF (-1), b=0x0, signed -> less=1.
5. Hold out_ready=0 for 5 cycles after out_valid and pulse in_valid with new operands -> out_valid, less, equal and greater stay stable and in_ready stays 0. On out_ready=1 the result clears, in_ready=1 next cycle, and a new operation is accepted and completes correctly.
6. Assert rst for 1 cycle on the 3rd COMPARE cycle -> the next cycle shows out_valid=0, in_ready=1, busy=0, with no stale result. A following compare of 0x5 vs 0x7 unsigned gives less=1.
